sample_tx: RTL

//   Transmit side of the capture read-back path. Accepts one WIDTH-bit sample word per

---
 rtl/logip_pkg.sv | 27 ++
 rtl/sample_tx_if.sv | 18 +
 rtl/uart_tx_byte.sv | 71 +++++++
 rtl/sample_tx.sv | 137 +++++++++++++
 4 files changed

// File: rtl/logip_pkg.sv
// Shared constants, sequencer state type and byte-select helper for the sample
// transmit path. The optional byte mask is enabled with LOGIP_TX_BYTE_MASK_EN.
package logip_pkg;

  localparam int   WIDTH     = 32;
  localparam int   BYTES     = WIDTH / 8;
  localparam int   DATA_BITS = 8;
  localparam logic START     = 1'b0;
  localparam logic STOP      = 1'b1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FRAME = 2'd1,
    DONE  = 2'd2
  } sample_tx_state_t;

  // Lowest set bit of m as {found, index}; {1'b0, 2'd0} when m is empty.
  function automatic logic [2:0] first_set(input logic [BYTES-1:0] m);
    logic [2:0] r;
    r = 3'b000;
    for (int i = BYTES - 1; i >= 0; i--) begin
      if (m[i]) r = {1'b1, 2'(i)};
    end
    return r;
  endfunction

endpackage

// File: rtl/sample_tx_if.sv
// Strobe/ready handshake between the capture FSM (master) and sample_tx (slave).
// byte_en exists only when LOGIP_TX_BYTE_MASK_EN is defined.
interface sample_tx_if;

  logic                          stb;
  logic [logip_pkg::WIDTH-1:0]   data;
  logic                          rdy;
`ifdef LOGIP_TX_BYTE_MASK_EN
  logic [logip_pkg::BYTES-1:0]   byte_en;

  modport master (output stb, data, byte_en, input rdy);
  modport slave  (input stb, data, byte_en, output rdy);
`else
  modport master (output stb, data, input rdy);
  modport slave  (input stb, data, output rdy);
`endif

endinterface

// File: rtl/uart_tx_byte.sv
// One 8N1 UART frame per accepted strobe. rdy_o is also high during the last cycle
// of the stop bit so a following frame can start with no gap.
module uart_tx_byte
  import logip_pkg::*;
#(
  parameter int CLKS_PER_BIT = 10
)
(
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       stb_i,
  input  logic [7:0] data_i,
  output logic       rdy_o,
  output logic       tx_o
);

  localparam int               CNT_W    = $clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] CNT_PRE  = CNT_W'(CLKS_PER_BIT - 2);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [3:0]       LAST_BIT = 4'(DATA_BITS + 1);

  logic             busy_r;
  logic [3:0]       bit_r;
  logic [CNT_W-1:0] cnt_r;
  logic [7:0]       shift_r;
  logic             tx_r;
  logic             rdy_r;

  // Frame sequencer: start bit, eight data bits shifted out LSB first, stop bit.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      busy_r  <= 1'b0;
      bit_r   <= 4'd0;
      cnt_r   <= '0;
      shift_r <= 8'd0;
      tx_r    <= STOP;
      rdy_r   <= 1'b1;
    end else if (stb_i && rdy_r) begin
      busy_r  <= 1'b1;
      bit_r   <= 4'd0;
      cnt_r   <= '0;
      shift_r <= data_i;
      tx_r    <= START;
      rdy_r   <= 1'b0;
    end else if (busy_r) begin
      if (cnt_r == CNT_LAST) begin
        cnt_r <= '0;
        if (bit_r == LAST_BIT) begin
          busy_r <= 1'b0;
          bit_r  <= 4'd0;
          tx_r   <= STOP;
        end else begin
          // Ones shifted in behind the data make the stop bit fall out naturally.
          bit_r   <= bit_r + 4'd1;
          tx_r    <= shift_r[0];
          shift_r <= {STOP, shift_r[7:1]};
        end
      end else begin
        cnt_r <= cnt_r + CNT_ONE;
      end
      if ((bit_r == LAST_BIT) && (cnt_r == CNT_PRE)) begin
        rdy_r <= 1'b1;
      end
    end
  end

  assign rdy_o = rdy_r;
  assign tx_o  = tx_r;

endmodule

// File: rtl/sample_tx.sv
// Serialises one WIDTH-bit sample as back-to-back 8N1 frames, byte 0 first.
// Define LOGIP_TX_BYTE_MASK_EN to add byte_en and skip disabled bytes.
module sample_tx
  import logip_pkg::*;
#(
  parameter int CLKS_PER_BIT = 10
)
(
  input  logic       clk_i,
  input  logic       rst_i,
  sample_tx_if.slave bus,
  output logic       tx_o
);

  sample_tx_state_t state_r;
  sample_tx_state_t state_next_s;
  logic             rdy_r;
  logic             rdy_next_s;
  logic [1:0]       idx_r;
  logic [1:0]       idx_next_s;
  logic [WIDTH-1:0] data_r;
  logic [BYTES-1:0] en_s;
  logic [BYTES-1:0] mask_in_s;
  logic [2:0]       sel_acc_s;
  logic [2:0]       sel_nxt_s;
  logic             accept_s;
  logic             sub_stb_s;
  logic             sub_rdy_s;
  logic [7:0]       sub_data_s;

`ifdef LOGIP_TX_BYTE_MASK_EN
  logic [BYTES-1:0] en_r;

  // Byte mask captured with the word it belongs to.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      en_r <= '0;
    end else if (accept_s) begin
      en_r <= bus.byte_en;
    end else begin
      en_r <= en_r;
    end
  end

  assign mask_in_s = bus.byte_en;
  assign en_s      = en_r;
`else
  assign mask_in_s = {BYTES{1'b1}};
  assign en_s      = {BYTES{1'b1}};
`endif

  assign accept_s  = rdy_r & bus.stb;
  assign sel_acc_s = first_set(mask_in_s);
  assign sel_nxt_s = first_set(en_s & (4'b1110 << idx_r));

  // Sequencer state, handshake and word registers.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_r <= IDLE;
      rdy_r   <= 1'b1;
      idx_r   <= 2'd0;
      data_r  <= '0;
    end else begin
      state_r <= state_next_s;
      rdy_r   <= rdy_next_s;
      idx_r   <= idx_next_s;
      if (accept_s) begin
        data_r <= bus.data;
      end else begin
        data_r <= data_r;
      end
    end
  end

  // Next state; the first frame is launched in the acceptance cycle itself so its
  // start bit appears right after acceptance, and later frames chain on frame end.
  always_comb begin
    state_next_s = state_r;
    rdy_next_s   = rdy_r;
    idx_next_s   = idx_r;
    sub_stb_s    = 1'b0;
    sub_data_s   = data_r[{idx_r, 3'b000} +: 8];
    case (state_r)
      IDLE, DONE: begin
        if (accept_s) begin
          rdy_next_s = 1'b0;
          if (sel_acc_s[2]) begin
            state_next_s = FRAME;
            idx_next_s   = sel_acc_s[1:0];
            sub_stb_s    = 1'b1;
            sub_data_s   = bus.data[{sel_acc_s[1:0], 3'b000} +: 8];
          end else begin
            state_next_s = DONE;
            idx_next_s   = 2'd0;
          end
        end else begin
          state_next_s = IDLE;
          rdy_next_s   = 1'b1;
        end
      end
      FRAME: begin
        if (sub_rdy_s) begin
          if (sel_nxt_s[2]) begin
            idx_next_s = sel_nxt_s[1:0];
            sub_stb_s  = 1'b1;
            sub_data_s = data_r[{sel_nxt_s[1:0], 3'b000} +: 8];
          end else begin
            // Ready rises as the last stop bit completes.
            state_next_s = DONE;
            rdy_next_s   = 1'b1;
          end
        end else begin
          state_next_s = FRAME;
        end
      end
      default: begin
        state_next_s = IDLE;
        rdy_next_s   = 1'b1;
        idx_next_s   = 2'd0;
      end
    endcase
  end

  uart_tx_byte #(
    .CLKS_PER_BIT (CLKS_PER_BIT)
  ) u_byte (
    .clk_i  (clk_i),
    .rst_i  (rst_i),
    .stb_i  (sub_stb_s),
    .data_i (sub_data_s),
    .rdy_o  (sub_rdy_s),
    .tx_o   (tx_o)
  );

  assign bus.rdy = rdy_r;

endmodule
